mul_div_unit: RTL and testbench
===============================

# mul_div_unit

- Iterative multiply/divide unit for the MIPS datapath.
- Sits directly downstream of the register file: consumes the rs/rt read-data words and holds the architectural HI/LO registers.
- Implements MULT, MULTU, DIV and DIVU as a 33-cycle shift-add / restoring-divide sequence with a start/busy/done handshake.
- Also services MTHI/MTLO writes and drives HI/LO to the writeback mux for MFHI/MFLO.

## Interface
- WIDTH, 32, operand width in bits; even, >= 4. The counter width is derived as clog2(WIDTH)+1.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only while idle.
- op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  WIDTH  multiplicand / dividend (register-file ReadData1).
- rt_data  input  WIDTH  multiplier / divisor (register-file ReadData2).
- mthi  input  1  write rs_data into HI.
- mtlo  input  1  write rs_data into LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when the HI/LO result has been committed.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Clock is one clock, `clk`; reset is synchronous and active-high, `reset`.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, with start=1 and a legal op:
  - Capture the magnitudes of rs_data/rt_data (signed ops take absolute values), the result-sign flags and op.
  - Clear the accumulator/partial remainder and set count=0; go to RUN.
- RUN, one iteration per cycle; count increments; after iteration WIDTH-1 go to FIX.
  - Multiply: 2*WIDTH-bit shift-add, LSB first.
  - Divide: restoring, MSB first, one quotient bit per cycle.
- FIX, one cycle:
  - Apply sign correction and write HI/LO.
  - Pulse done and return to IDLE.
- Result placement:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Signed division:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative / -1 gives LO=0x80000000, HI=0; no exception.
- Divide by zero, any signedness: LO=all ones, HI=rs_data (dividend as supplied).
- hi/lo keep their old values throughout RUN; they change only at the FIX edge, on MTHI/MTLO, or on reset.
- MTHI/MTLO:
  - Honoured only in IDLE; HI or LO takes rs_data at the edge.
  - mthi and mtlo together write both.
  - Ignored while busy.
- start and mthi/mtlo in the same idle cycle: start wins, the move is dropped.
- start while busy: ignored, with no queueing.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, count=0.
- Reset asserted mid-operation aborts the operation in the same edge: no done, HI/LO cleared.
- Edge numbering for an accepted operation:
  - Edge E0: start sampled.
  - Edges E1..E32: iterations (WIDTH=32).
  - Edge E33: FIX commits the result.
- busy=1 from after E0 through before E33+1, i.e. 33 cycles.
- done=1 for exactly the cycle after E33, with busy=0 in that cycle.
- New results are visible on hi/lo in the done cycle.
- Back-to-back: start in the done cycle is accepted, so the next E0 is the edge ending the done cycle.
- MTHI/MTLO: zero latency; the new value appears on hi/lo in the cycle after the write edge.
- Operand inputs are sampled only at E0; they may change freely afterwards.

## Configuration
- Macro MDU_DIVIDE_EN.
- Defined: full behaviour as above.
- Undefined:
  - Divider datapath is not built.
  - start with op[1]=1 is ignored: busy stays 0, no done, HI/LO unchanged.
  - Multiply, MTHI and MTLO are unaffected.

## Test plan
- MULT, rs=0xFFFFFFFD (-3), rt=5 -> done 34 edges after E0; HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high 33 cycles.
- MULTU, rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100. DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI rs=0x12345678 while idle -> hi=0x12345678 next cycle. Then start MULTU 6*7 and pulse mtlo plus a second start during RUN -> both ignored; result HI=0, LO=42.
- Start DIVU 50/7 and assert reset at iteration 10 -> the following cycle has busy=0, done never pulses, hi=lo=0. Then start DIVU 50/7 -> LO=7, HI=1.
- Build without MDU_DIVIDE_EN:
  - start DIV 9/3 -> busy stays 0, no done, HI/LO unchanged.
  - MULT 3*3 -> LO=9.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the decode/register-file side
// (master) and the multiply/divide unit (slave).
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_data, rt_data, mthi, mtlo,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, rs_data, rt_data, mthi, mtlo,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit owning HI/LO.
// MULT/MULTU run an LSB-first shift-add, DIV/DIVU a restoring divide, one bit
// per cycle for WIDTH cycles, then one sign-fix cycle commits HI/LO.
// Macro MDU_DIVIDE_EN builds the divider; without it divide starts are ignored.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accHi;   // product high half / partial remainder
  logic [WIDTH-1:0] lowReg;  // multiplier shifting out, or dividend turning into quotient
  logic [WIDTH-1:0] opB;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hiReg, loReg;
  logic             negQ, doneReg;
  logic             legal, accept, lastIter;
  logic             signedOp, rsNeg, rtNeg;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   mulSum;
  logic [2*WIDTH-1:0] prodFix;

`ifdef MDU_DIVIDE_EN
  logic             isDiv, negR, remLess;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] remSub, quoFix, remFix;

  assign legal    = 1'b1;
  assign remShift = {accHi, lowReg[WIDTH-1]};
  assign remLess  = remShift < {1'b0, opB};
  // Only used when no borrow, so the difference is below the divisor and fits.
  assign remSub   = remShift[WIDTH-1:0] - opB;
  assign quoFix   = negQ ? -lowReg : lowReg;
  assign remFix   = negR ? -accHi : accHi;
`else
  assign legal    = ~bus.op[1];
`endif

  assign accept   = (state == IDLE) && bus.start && legal;
  assign lastIter = (count == CW'(WIDTH - 1));
  assign signedOp = ~bus.op[0];
  assign rsNeg    = signedOp & bus.rs_data[WIDTH-1];
  assign rtNeg    = signedOp & bus.rt_data[WIDTH-1];
  assign magA     = rsNeg ? -bus.rs_data : bus.rs_data;
  assign magB     = rtNeg ? -bus.rt_data : bus.rt_data;
  assign mulSum   = {1'b0, accHi} + (lowReg[0] ? {1'b0, opB} : '0);
  assign prodFix  = negQ ? -{accHi, lowReg} : {accHi, lowReg};

  assign bus.busy = (state != IDLE);
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state: idle until an accepted start, WIDTH iterations, one fix cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (lastIter) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand capture, one iteration per RUN cycle, commit in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      accHi   <= '0;
      lowReg  <= '0;
      opB     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      negQ    <= 1'b0;
      doneReg <= 1'b0;
`ifdef MDU_DIVIDE_EN
      isDiv   <= 1'b0;
      negR    <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count  <= '0;
            accHi  <= '0;
            lowReg <= magA;
            opB    <= magB;
            // A zero divisor must leave the all-ones quotient unnegated.
            negQ   <= (rsNeg ^ rtNeg) & (|bus.rt_data);
`ifdef MDU_DIVIDE_EN
            isDiv  <= bus.op[1];
            negR   <= rsNeg;
`endif
          end else begin
            if (bus.mthi) hiReg <= bus.rs_data;
            if (bus.mtlo) loReg <= bus.rs_data;
          end
        end
        RUN: begin
          count <= count + 1'b1;
`ifdef MDU_DIVIDE_EN
          if (isDiv) begin
            accHi  <= remLess ? remShift[WIDTH-1:0] : remSub;
            lowReg <= {lowReg[WIDTH-2:0], ~remLess};
          end else
`endif
          {accHi, lowReg} <= {mulSum, lowReg[WIDTH-1:1]};
        end
        FIX: begin
          doneReg <= 1'b1;
`ifdef MDU_DIVIDE_EN
          if (isDiv) begin
            hiReg <= remFix;
            loReg <= quoFix;
          end else
`endif
          {hiReg, loReg} <= prodFix;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against a
// plain-arithmetic model of MIPS MULT/MULTU/DIV/DIVU. Honours MDU_DIVIDE_EN.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mul_div_unit_if #(.WIDTH(32)) bus();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  // {HI,LO} as the ISA defines them.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0:    r = 64'(sa * sb);
      2'd1:    r = {32'b0, a} * {32'b0, b};
      2'd2:    r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Present a start; returns just after the E0 edge with operands scrambled.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, b, input bit immediate);
    if (!immediate) @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.rs_data = $urandom; bus.rt_data = $urandom;
  endtask

  // Observe until done (bounded); lat counts cycles after E0 up to the done cycle.
  task automatic waitDone(output int lat, output int busyCnt, output bit busyAtDone,
                          output bit stable, output logic [31:0] h, output logic [31:0] l);
    logic [31:0] h0, l0;
    h0 = bus.hi; l0 = bus.lo;
    lat = 0; busyCnt = 0; busyAtDone = 1'b1; stable = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin busyAtDone = bus.busy; break; end
      if (bus.busy) busyCnt++;
      if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
    end
    h = bus.hi; l = bus.lo;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0; bus.mthi = 0; bus.mtlo = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
  endtask

  task automatic test_mult();
    logic [1:0]  ops [2] = '{2'd0, 2'd1};
    logic [31:0] as  [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [31:0] bs  [2] = '{32'd5, 32'hFFFFFFFF};
    int lat, bc; bit bad, st; logic [31:0] h, l; logic [63:0] e;
    for (int i = 0; i < 2; i++) begin
      e = model(ops[i], as[i], bs[i]);
      launch(ops[i], as[i], bs[i], 1'b0);
      waitDone(lat, bc, bad, st, h, l);
      checks++; if (lat !== 34 || bc !== 33 || bad !== 1'b0) begin errors++;
        $display("FAIL mult_timing[%0d] got lat=%0d busy=%0d busyAtDone=%b want 34/33/0", i, lat, bc, bad); end
      checks++; if (!st) begin errors++; $display("FAIL mult_hilo_hold[%0d] got changed want held", i); end
      checks++; if (h !== e[63:32] || l !== e[31:0]) begin errors++;
        $display("FAIL mult_result[%0d] got hi=%h lo=%h want hi=%h lo=%h", i, h, l, e[63:32], e[31:0]); end
    end
  endtask

`ifdef MDU_DIVIDE_EN
  task automatic test_divide();
    logic [1:0]  ops [4] = '{2'd2, 2'd3, 2'd2, 2'd2};
    logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] bs  [4] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
    int lat, bc; bit bad, st; logic [31:0] h, l; logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      e = model(ops[i], as[i], bs[i]);
      launch(ops[i], as[i], bs[i], 1'b0);
      waitDone(lat, bc, bad, st, h, l);
      checks++; if (lat !== 34 || bc !== 33 || bad !== 1'b0 || !st) begin errors++;
        $display("FAIL div_timing[%0d] got lat=%0d busy=%0d busyAtDone=%b held=%b want 34/33/0/1", i, lat, bc, bad, st); end
      checks++; if (h !== e[63:32] || l !== e[31:0]) begin errors++;
        $display("FAIL div_result[%0d] got hi=%h lo=%h want hi=%h lo=%h", i, h, l, e[63:32], e[31:0]); end
    end
  endtask
`endif

  task automatic test_move();
    int lat, bc; bit bad, st; logic [31:0] h, l, lo0;
    @(negedge clk); bus.mthi = 1'b1; bus.rs_data = 32'h12345678;
    @(posedge clk); #1 bus.mthi = 1'b0;
    @(negedge clk);
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi got=%h want=12345678", bus.hi); end
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.rs_data = 32'hCAFEF00D;
    @(posedge clk); #1 bus.mthi = 1'b0; bus.mtlo = 1'b0;
    @(negedge clk);
    checks++; if (bus.hi !== 32'hCAFEF00D || bus.lo !== 32'hCAFEF00D) begin errors++;
      $display("FAIL mthi_mtlo got hi=%h lo=%h want both cafef00d", bus.hi, bus.lo); end
    lo0 = bus.lo;
    launch(2'd1, 32'd6, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    bus.mtlo = 1'b1; bus.start = 1'b1; bus.op = 2'd0; bus.rs_data = 32'hDEAD0000;
    @(negedge clk);
    bus.mtlo = 1'b0; bus.start = 1'b0;
    checks++; if (bus.lo !== lo0 || bus.busy !== 1'b1) begin errors++;
      $display("FAIL mtlo_while_busy got lo=%h busy=%b want lo=%h busy=1", bus.lo, bus.busy, lo0); end
    waitDone(lat, bc, bad, st, h, l);
    checks++; if (h !== 32'h0 || l !== 32'd42 || lat > 30) begin errors++;
      $display("FAIL busy_ignore_result got hi=%h lo=%h want hi=0 lo=2a", h, l); end
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_not_queued got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_start_wins();
    int lat, bc; bit bad, st; logic [31:0] h, l;
    @(negedge clk); bus.mthi = 1'b1;
    launch(2'd1, 32'd2, 32'd3, 1'b1);
    bus.mthi = 1'b0;
    waitDone(lat, bc, bad, st, h, l);
    checks++; if (h !== 32'h0 || l !== 32'd6 || !st) begin errors++;
      $display("FAIL start_beats_move got hi=%h lo=%h held=%b want hi=0 lo=6 held=1", h, l, st); end
  endtask

  task automatic test_abort();
    int lat, bc; bit bad, st, sawDone; logic [31:0] h, l; logic [1:0] o; logic [63:0] e;
`ifdef MDU_DIVIDE_EN
    o = 2'd3;
`else
    o = 2'd1;
`endif
    e = model(o, 32'd50, 32'd7);
    launch(o, 32'd50, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++;
      $display("FAIL abort_state got busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo); end
    sawDone = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done || bus.busy) sawDone = 1'b1; end
    checks++; if (sawDone) begin errors++; $display("FAIL abort_no_done got activity want none"); end
    launch(o, 32'd50, 32'd7, 1'b0);
    waitDone(lat, bc, bad, st, h, l);
    checks++; if (lat !== 34 || h !== e[63:32] || l !== e[31:0]) begin errors++;
      $display("FAIL after_abort got lat=%0d hi=%h lo=%h want 34 hi=%h lo=%h", lat, h, l, e[63:32], e[31:0]); end
  endtask

  task automatic test_random();
    int lat, bc; bit bad, st; logic [31:0] a, b, h, l; logic [1:0] o; logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
`ifndef MDU_DIVIDE_EN
      o[1] = 1'b0;
`endif
      a = pick(); b = pick();
      e = model(o, a, b);
      launch(o, a, b, (i % 2) == 1);
      waitDone(lat, bc, bad, st, h, l);
      checks++; if (lat !== 34 || bc !== 33 || h !== e[63:32] || l !== e[31:0]) begin errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got lat=%0d busy=%0d hi=%h lo=%h want 34/33 hi=%h lo=%h",
                 i, o, a, b, lat, bc, h, l, e[63:32], e[31:0]); end
    end
  endtask

`ifndef MDU_DIVIDE_EN
  task automatic test_nodiv();
    int lat, bc; bit bad, st, active; logic [31:0] h, l, h0, l0;
    h0 = bus.hi; l0 = bus.lo; active = 1'b0;
    launch(2'd2, 32'd9, 32'd3, 1'b0);
    repeat (40) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.hi !== h0 || bus.lo !== l0) active = 1'b1;
    end
    checks++; if (active) begin errors++; $display("FAIL nodiv_ignored got activity want none"); end
    launch(2'd0, 32'd3, 32'd3, 1'b0);
    waitDone(lat, bc, bad, st, h, l);
    checks++; if (lat !== 34 || h !== 32'h0 || l !== 32'd9) begin errors++;
      $display("FAIL nodiv_mult got lat=%0d hi=%h lo=%h want 34 hi=0 lo=9", lat, h, l); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
`ifdef MDU_DIVIDE_EN
    test_divide();
`else
    test_nodiv();
`endif
    test_move();
    test_start_wins();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
